// File: rtl/mealy_scheduler.sv
// Round-robin share of one serial pair detector between two word requesters; result valid WIDTH+2 edges after accept.
// Requesters are ready only in IDLE; a stalled result (res_ready low) holds DONE and blocks new grants.
module mealy_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req0_valid,
  input  logic [WIDTH-1:0]                 req0_data,
  output logic                             req0_ready,
  input  logic                             req1_valid,
  input  logic [WIDTH-1:0]                 req1_data,
  output logic                             req1_ready,
  output logic                             det_rst,
  output logic                             det_inp,
  input  logic                             det_outp,
  output logic                             res_valid,
  output logic                             res_id,
  output logic [WIDTH-1:0]                 res_flags,
  output logic [$clog2(WIDTH+1)-1:0]       res_count,
  input  logic                             res_ready
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH-1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CW-1:0]    count_q, count_d;
  logic             grant0, grant1;

  // ptr_q names the requester that wins when both ask at once
  assign grant0 = req0_valid && (!req1_valid || !ptr_q);
  assign grant1 = req1_valid && (!req0_valid ||  ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    idx_d      = idx_q;
    res_id_d   = res_id_q;
    flags_d    = flags_q;
    count_d    = count_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    det_rst    = 1'b1;
    det_inp    = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          word_d   = grant1 ? req1_data : req0_data;
          res_id_d = grant1;
          flags_d  = '0;
          count_d  = '0;
          ptr_d    = !grant1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        det_rst = 1'b0;
        det_inp = word_q[idx_q];
        idx_d   = idx_q + IW'(1);
        // detector output lags its input by one cycle
        if (idx_q != '0) begin
          flags_d[idx_q - IW'(1)] = det_outp;
          count_d = count_q + CW'(det_outp);
        end
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        det_rst            = 1'b0;
        flags_d[WIDTH-1]   = det_outp;
        count_d            = count_q + CW'(det_outp);
        state_d            = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a pending reset must not leak a handshake or detector activity
    if (!rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      det_rst    = 1'b1;
      det_inp    = 1'b0;
      res_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      word_q   <= '0;
      idx_q    <= '0;
      res_id_q <= 1'b0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      res_id_q <= res_id_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  assign res_id    = res_id_q;
  assign res_flags = flags_q;
  assign res_count = count_q;
endmodule
